route_compute: RTL and testbench

//  Route-computation stage of the dynamic router. Sits directly downstream of the input_unit input queue.

---
 rtl/route_compute_pkg.sv | 55 +++++
 rtl/route_compute_if.sv | 22 ++
 rtl/route_compute_route_calc.sv | 36 +++
 rtl/route_compute.sv | 153 +++++++++++++++
 tb/tb_route_compute.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/route_compute_pkg.sv
// Shared field layout, flit-type and port codes, and helpers for the route-computation stage.
package route_compute_pkg;

  localparam int unsigned FlitSizeDefault = 64;
  localparam int unsigned DimDefault      = 8;
  localparam int unsigned TypeW           = 2;
  localparam int unsigned DstW            = 9;
  localparam int unsigned CheckW          = 4;
  localparam int unsigned PortW           = 3;

  typedef enum logic [1:0] {
    FlitHead   = 2'd0,
    FlitBody   = 2'd1,
    FlitTail   = 2'd2,
    FlitSingle = 2'd3
  } flit_type_e;

  typedef enum logic [PortW-1:0] {
    PortXPos  = 3'd0,
    PortXNeg  = 3'd1,
    PortYPos  = 3'd2,
    PortYNeg  = 3'd3,
    PortZPos  = 3'd4,
    PortZNeg  = 3'd5,
    PortLocal = 3'd6
  } port_e;

  typedef enum logic [1:0] {
    StIdle,
    StRouted,
    StDrop
  } state_e;

  typedef struct packed {
    logic [2:0] dx;
    logic [2:0] dy;
    logic [2:0] dz;
  } dst_t;

  function automatic logic [CheckW-1:0] check_calc(logic [TypeW-1:0] t, dst_t d);
    return {2'b00, t} ^ {1'b0, d.dx} ^ {1'b0, d.dy} ^ {1'b0, d.dz};
  endfunction

  // Forward distance around a ring, in 4 bits; out-of-range coords wrap mod dim.
  function automatic logic [3:0] ring_delta(logic [2:0] c, logic [2:0] own, int unsigned dim);
    logic [3:0] w_dim;
    logic [3:0] w_cm;
    logic [3:0] w_om;
    w_dim = 4'(dim);
    w_cm  = {1'b0, c} % w_dim;
    w_om  = {1'b0, own} % w_dim;
    return (w_cm >= w_om) ? (w_cm - w_om) : (w_cm + w_dim - w_om);
  endfunction

endpackage

// File: rtl/route_compute_if.sv
// Input-queue pop channel and downstream valid/ready channel of the route-computation stage.
interface route_compute_if #(
  parameter int unsigned FLIT_SIZE = 64
);
  logic [FLIT_SIZE-1:0] deq_data;
  logic                 deq_empty;
  logic                 dequeue;
  logic [FLIT_SIZE-1:0] out_data;
  logic [2:0]           out_port;
  logic                 out_valid;
  logic                 out_ready;

  modport slave (
    input  deq_data, deq_empty, out_ready,
    output dequeue, out_data, out_port, out_valid
  );

  modport master (
    output deq_data, deq_empty, out_ready,
    input  dequeue, out_data, out_port, out_valid
  );
endinterface

// File: rtl/route_compute_route_calc.sv
// Dimension-order (X, then Y, then Z) shortest-path output-port selection on a 3-D torus.
module route_calc
  import route_compute_pkg::*;
#(
  parameter logic [2:0]  X     = 3'd0,
  parameter logic [2:0]  Y     = 3'd0,
  parameter logic [2:0]  Z     = 3'd0,
  parameter int unsigned DIM_X = DimDefault,
  parameter int unsigned DIM_Y = DimDefault,
  parameter int unsigned DIM_Z = DimDefault
) (
  input  dst_t  i_dst,
  output port_e o_port
);

  logic [3:0] w_dx;
  logic [3:0] w_dy;
  logic [3:0] w_dz;

  assign w_dx = ring_delta(i_dst.dx, X, DIM_X);
  assign w_dy = ring_delta(i_dst.dy, Y, DIM_Y);
  assign w_dz = ring_delta(i_dst.dz, Z, DIM_Z);

  // Half-way ties go the positive direction.
  always_comb begin
    o_port = PortLocal;
    if (w_dx != 4'd0) begin
      o_port = (w_dx <= 4'(DIM_X / 2)) ? PortXPos : PortXNeg;
    end else if (w_dy != 4'd0) begin
      o_port = (w_dy <= 4'(DIM_Y / 2)) ? PortYPos : PortYNeg;
    end else if (w_dz != 4'd0) begin
      o_port = (w_dz <= 4'(DIM_Z / 2)) ? PortZPos : PortZNeg;
    end
  end

endmodule

// File: rtl/route_compute.sv
// Route-computation stage: pops the input queue, checks head flits, routes and locks the
// output port per packet (wormhole), and hands flit+port downstream through a 2-entry skid FIFO.
module route_compute
  import route_compute_pkg::*;
#(
  parameter logic [2:0]  X         = 3'd0,
  parameter logic [2:0]  Y         = 3'd0,
  parameter logic [2:0]  Z         = 3'd0,
  parameter int unsigned DIM_X     = DimDefault,
  parameter int unsigned DIM_Y     = DimDefault,
  parameter int unsigned DIM_Z     = DimDefault,
  parameter int unsigned FLIT_SIZE = FlitSizeDefault
) (
  input  logic              clk,
  input  logic              rst,
  route_compute_if.slave    rc,
  output logic [15:0]       err_count
);

  localparam int unsigned TypeLsb  = FLIT_SIZE - TypeW;
  localparam int unsigned DstLsb   = TypeLsb - DstW;
  localparam int unsigned CheckLsb = DstLsb - CheckW;

  flit_type_e           w_type;
  dst_t                 w_dst;
  logic [CheckW-1:0]    w_check;
  logic                 w_good;
  port_e                w_route_port;

  state_e               r_state;
  state_e               w_state_d;

  logic [1:0]           r_count;
  logic                 r_rd_ptr;
  logic                 r_wr_ptr;
  logic [FLIT_SIZE-1:0] r_data [2];
  port_e                r_port [2];
  port_e                r_pkt_port;
  logic [15:0]          r_err;

  logic                 w_pop_in;
  logic                 w_push;
  logic                 w_drop;
  logic                 w_latch;
  logic                 w_eval;
  logic                 w_out_fire;
  port_e                w_push_port;

  assign w_type  = flit_type_e'(rc.deq_data[TypeLsb +: TypeW]);
  assign w_dst   = rc.deq_data[DstLsb +: DstW];
  assign w_check = rc.deq_data[CheckLsb +: CheckW];
  assign w_good  = (w_check == check_calc(w_type, w_dst));

  route_calc #(
    .X     (X),
    .Y     (Y),
    .Z     (Z),
    .DIM_X (DIM_X),
    .DIM_Y (DIM_Y),
    .DIM_Z (DIM_Z)
  ) u_route_calc (
    .i_dst  (w_dst),
    .o_port (w_route_port)
  );

  // Pop depends only on registered occupancy, never on out_ready.
  assign w_pop_in   = !rc.deq_empty && (r_count != 2'd2) && !rst;
  assign w_out_fire = rc.out_valid && rc.out_ready;

  assign rc.dequeue   = w_pop_in;
  assign rc.out_valid = (r_count != 2'd0);
  assign rc.out_data  = r_data[r_rd_ptr];
  assign rc.out_port  = r_port[r_rd_ptr];
  assign err_count    = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    if (w_pop_in) begin
      case (r_state)
        StIdle, StDrop: begin
          if (w_type == FlitHead) begin
            w_state_d = w_good ? StRouted : StDrop;
          end else if (w_type == FlitTail) begin
            w_state_d = StIdle;
          end
        end
        StRouted: begin
          if (w_type == FlitTail) begin
            w_state_d = StIdle;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  // A HEAD seen while dropping restarts evaluation exactly as from idle.
  always_comb begin
    w_eval      = (r_state == StIdle) || ((r_state == StDrop) && (w_type == FlitHead));
    w_push      = 1'b0;
    w_latch     = 1'b0;
    w_push_port = w_route_port;
    if (w_pop_in) begin
      if (w_eval) begin
        w_push  = w_good && ((w_type == FlitHead) || (w_type == FlitSingle));
        w_latch = w_push && (w_type == FlitHead);
      end else if (r_state == StRouted) begin
        w_push      = (w_type == FlitBody) || (w_type == FlitTail);
        w_push_port = r_pkt_port;
      end
    end
    w_drop = w_pop_in && !w_push;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= 2'd0;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_pkt_port <= PortXPos;
      r_err      <= 16'd0;
      for (int i = 0; i < 2; i++) begin
        r_data[i] <= '0;
        r_port[i] <= PortXPos;
      end
    end else begin
      if (w_push) begin
        r_data[r_wr_ptr] <= rc.deq_data;
        r_port[r_wr_ptr] <= w_push_port;
        r_wr_ptr         <= !r_wr_ptr;
      end
      if (w_out_fire) begin
        r_rd_ptr <= !r_rd_ptr;
      end
      r_count <= r_count + 2'(w_push) - 2'(w_out_fire);
      if (w_latch) begin
        r_pkt_port <= w_route_port;
      end
      if (w_drop && (r_err != 16'hFFFF)) begin
        r_err <= r_err + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_route_compute.sv
// Directed bench for route_compute: routing, wormhole locking, skid stalls, drops and reset.
module tb_route_compute;
  import route_compute_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] err_count;

  route_compute_if #(.FLIT_SIZE(64)) rc ();

  route_compute #(
    .X         (3'd0),
    .Y         (3'd0),
    .Z         (3'd0),
    .DIM_X     (8),
    .DIM_Y     (8),
    .DIM_Z     (8),
    .FLIT_SIZE (64)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rc        (rc),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int n_pops   = 0;
  int n_out    = 0;

  logic [63:0] src[$];
  logic [63:0] exp_data[$];
  logic [2:0]  exp_port[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h @%0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [63:0] mk(input logic [1:0] t, input logic [2:0] dx,
                                     input logic [2:0] dy, input logic [2:0] dz,
                                     input logic [48:0] pl, input bit bad);
    logic [3:0] c;
    c = {2'b00, t} ^ {1'b0, dx} ^ {1'b0, dy} ^ {1'b0, dz};
    if (bad) c = ~c;
    return {t, dx, dy, dz, c, pl};
  endfunction

  // Own coords are 0 on rings of 8, so the forward distance is the coordinate itself.
  function automatic logic [2:0] ref_port(input int dx, input int dy, input int dz);
    if (dx != 0) return (dx <= 4) ? 3'd0 : 3'd1;
    if (dy != 0) return (dy <= 4) ? 3'd2 : 3'd3;
    if (dz != 0) return (dz <= 4) ? 3'd4 : 3'd5;
    return 3'd6;
  endfunction

  task automatic send(input logic [63:0] f, input logic [2:0] p, input bit kept);
    src.push_back(f);
    if (kept) begin
      exp_data.push_back(f);
      exp_port.push_back(p);
    end
  endtask

  task automatic tick();
    bit pop;
    bit acc;
    rc.deq_empty = (src.size() == 0);
    rc.deq_data  = (src.size() == 0) ? 64'h0 : src[0];
    #1;
    pop = rc.dequeue;
    acc = rc.out_valid && rc.out_ready;
    if (acc) begin
      n_out++;
      if (exp_data.size() == 0) begin
        check_eq("spurious_out", 64'(exp_data.size()), 64'd1);
      end else begin
        check_eq("out_data", rc.out_data, exp_data.pop_front());
        check_eq("out_port", 64'(rc.out_port), 64'(exp_port.pop_front()));
      end
    end
    @(posedge clk);
    if (pop && (src.size() != 0)) begin
      void'(src.pop_front());
      n_pops++;
    end
    @(negedge clk);
  endtask

  task automatic drain(input int budget, input bit toggle);
    int i = 0;
    while (((src.size() != 0) || (exp_data.size() != 0)) && (i < budget)) begin
      if (toggle) rc.out_ready = ~rc.out_ready;
      tick();
      i++;
    end
    check_eq("drain_left", 64'(src.size() + exp_data.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    rc.deq_empty = 1'b1;
    rc.deq_data  = 64'h0;
    src.delete();
    exp_data.delete();
    exp_port.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [63:0] h;
    int          total;
    rst          = 1'b1;
    rc.out_ready = 1'b0;
    rc.deq_empty = 1'b0;
    rc.deq_data  = mk(2'd3, 3'd1, 3'd0, 3'd0, 49'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("rst_dequeue", 64'(rc.dequeue), 64'd0);
    rst          = 1'b0;
    rc.deq_empty = 1'b1;
    #1;
    check_eq("rst_valid", 64'(rc.out_valid), 64'd0);
    check_eq("rst_data", rc.out_data, 64'd0);
    check_eq("rst_port", 64'(rc.out_port), 64'd0);
    check_eq("rst_err", 64'(err_count), 64'd0);
    @(negedge clk);

    // 1: single flit, next-cycle latency
    rc.out_ready = 1'b1;
    h = mk(2'd3, 3'd3, 3'd5, 3'd1, 49'h1111, 1'b0);
    send(h, 3'd0, 1'b1);
    tick();
    #1;
    check_eq("t1_valid", 64'(rc.out_valid), 64'd1);
    check_eq("t1_port", 64'(rc.out_port), 64'd0);
    check_eq("t1_data", rc.out_data, h);
    drain(10, 1'b0);
    check_eq("t1_err", 64'(err_count), 64'd0);

    // 2: port selection incl. tie and wrap
    send(mk(2'd3, 3'd5, 3'd0, 3'd0, 49'h21, 1'b0), 3'd1, 1'b1);
    send(mk(2'd3, 3'd4, 3'd0, 3'd0, 49'h22, 1'b0), 3'd0, 1'b1);
    send(mk(2'd3, 3'd0, 3'd0, 3'd7, 49'h23, 1'b0), 3'd5, 1'b1);
    send(mk(2'd3, 3'd0, 3'd0, 3'd0, 49'h24, 1'b0), 3'd6, 1'b1);
    send(mk(2'd3, 3'd0, 3'd6, 3'd0, 49'h25, 1'b0), 3'd3, 1'b1);
    send(mk(2'd3, 3'd0, 3'd0, 3'd2, 49'h26, 1'b0), 3'd4, 1'b1);
    drain(30, 1'b0);

    // 3: 5-flit packet with downstream stalled for 5 cycles
    rc.out_ready = 1'b0;
    n_pops       = 0;
    h = mk(2'd0, 3'd0, 3'd2, 3'd0, 49'h31, 1'b0);
    send(h, 3'd2, 1'b1);
    for (int i = 0; i < 3; i++) send(mk(2'd1, 3'd7, 3'd7, 3'd7, 49'(32 + i), 1'b0), 3'd2, 1'b1);
    send(mk(2'd2, 3'd1, 3'd1, 3'd1, 49'h35, 1'b0), 3'd2, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("t3_hold", rc.out_data, h);
    end
    check_eq("t3_pops", 64'(n_pops), 64'd2);
    rc.out_ready = 1'b1;
    drain(30, 1'b0);
    check_eq("t3_err", 64'(err_count), 64'd0);

    // 4: corrupt head, its body/tail dropped, then a good single
    send(mk(2'd0, 3'd1, 3'd0, 3'd0, 49'h41, 1'b1), 3'd0, 1'b0);
    send(mk(2'd1, 3'd0, 3'd0, 3'd0, 49'h42, 1'b0), 3'd0, 1'b0);
    send(mk(2'd2, 3'd0, 3'd0, 3'd0, 49'h43, 1'b0), 3'd0, 1'b0);
    send(mk(2'd3, 3'd0, 3'd0, 3'd0, 49'h44, 1'b0), 3'd6, 1'b1);
    drain(20, 1'b0);
    check_eq("t4_err", 64'(err_count), 64'd3);

    // 5: reset mid-packet, trailing tail becomes an orphan
    rc.out_ready = 1'b0;
    send(mk(2'd0, 3'd1, 3'd0, 3'd0, 49'h51, 1'b0), 3'd0, 1'b1);
    send(mk(2'd1, 3'd0, 3'd0, 3'd0, 49'h52, 1'b0), 3'd0, 1'b1);
    tick();
    tick();
    check_eq("t5_pre_valid", 64'(rc.out_valid), 64'd1);
    do_reset();
    #1;
    check_eq("t5_valid", 64'(rc.out_valid), 64'd0);
    check_eq("t5_data", rc.out_data, 64'd0);
    check_eq("t5_port", 64'(rc.out_port), 64'd0);
    check_eq("t5_err0", 64'(err_count), 64'd0);
    rc.out_ready = 1'b1;
    send(mk(2'd2, 3'd0, 3'd0, 3'd0, 49'h53, 1'b0), 3'd0, 1'b0);
    drain(10, 1'b0);
    check_eq("t5_err", 64'(err_count), 64'd1);
    check_eq("t5_empty", 64'(rc.out_valid), 64'd0);

    // 6: random packets with out_ready toggling every cycle
    n_out = 0;
    total = 0;
    for (int p = 0; p < 12; p++) begin
      int dx;
      int dy;
      int dz;
      logic [2:0] pt;
      dx = $urandom_range(0, 7);
      dy = $urandom_range(0, 7);
      dz = $urandom_range(0, 7);
      pt = ref_port(dx, dy, dz);
      if ($urandom_range(0, 1) == 0) begin
        send(mk(2'd3, 3'(dx), 3'(dy), 3'(dz), 49'(p), 1'b0), pt, 1'b1);
        total++;
      end else begin
        int nb;
        nb = $urandom_range(0, 2);
        send(mk(2'd0, 3'(dx), 3'(dy), 3'(dz), 49'(p * 16), 1'b0), pt, 1'b1);
        for (int b = 0; b < nb; b++) begin
          send(mk(2'd1, 3'($urandom_range(0, 7)), 3'd0, 3'd0, 49'(p * 16 + b + 1), 1'b0),
               pt, 1'b1);
        end
        send(mk(2'd2, 3'd0, 3'd0, 3'd0, 49'(p * 16 + 15), 1'b0), pt, 1'b1);
        total += nb + 2;
      end
    end
    drain(400, 1'b1);
    check_eq("t6_count", 64'(n_out), 64'(total));
    check_eq("t6_err", 64'(err_count), 64'd1);

    // 7: saturation under a stream of orphan bodies
    do_reset();
    rc.out_ready = 1'b1;
    rc.deq_empty = 1'b0;
    rc.deq_data  = mk(2'd1, 3'd2, 3'd0, 3'd0, 49'h71, 1'b0);
    repeat (65534) @(posedge clk);
    #1;
    check_eq("t7_fffe", 64'(err_count), 64'hFFFE);
    @(posedge clk);
    #1;
    check_eq("t7_ffff", 64'(err_count), 64'hFFFF);
    repeat (4) @(posedge clk);
    #1;
    check_eq("t7_sat", 64'(err_count), 64'hFFFF);
    check_eq("t7_valid", 64'(rc.out_valid), 64'd0);
    rc.deq_empty = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
